// File: rtl/log_mul_seq.sv
// Iterative Mitchell logarithmic multiplier. One leading-one detector is
// time-shared between the two operands; an operation takes one accept cycle,
// two detect cycles, one antilog cycle and a DONE cycle that holds the result
// until the consumer takes it.

// Leading-one position detector: index of the most significant set bit.
// The output for an all-zero input carries no meaning.
module lopd #(
  parameter int WIDTH_I = 16,
  parameter int WIDTH_L = $clog2(WIDTH_I)
) (
  input  logic [WIDTH_I-1:0] x,
  output logic [WIDTH_L-1:0] k
);

  // Priority scan from the LSB so that the highest set bit wins.
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH_I; i++) begin
      if (x[i]) k = WIDTH_L'(i);
    end
  end

endmodule

module log_mul_seq #(
  parameter int WIDTH_I = 16,
  parameter int WIDTH_L = $clog2(WIDTH_I)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_I-1:0]     a,
  input  logic [WIDTH_I-1:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH_I-1:0]   p,
  output logic                   busy
);

  // Fraction width of the log mantissa is tied to the operand width.
  localparam int F  = WIDTH_I - 1;
  // Working width for the antilog shift so that no intermediate bit is lost.
  localparam int PW = 2*WIDTH_I + F;

  typedef enum logic [2:0] {
    IDLE,
    LOPD_A,
    LOPD_B,
    CALC,
    DONE
  } state_t;

  state_t state, state_d;

  logic [WIDTH_I-1:0] opa, opb;
  logic [WIDTH_L-1:0] ka, kb;
  logic [F-1:0]       fa, fb;
  logic               zf;

  logic [WIDTH_I-1:0] lopd_in;
  logic [WIDTH_L-1:0] lopd_k;

  // Mantissa fraction: the bits below the leading one, left-aligned to F bits.
  function automatic logic [F-1:0] frac_of(input logic [WIDTH_I-1:0] x,
                                           input logic [WIDTH_L-1:0] k);
    logic [WIDTH_L:0]   amt;
    logic [WIDTH_I-1:0] sh;
    amt = (WIDTH_L+1)'(F) - {1'b0, k};
    sh  = x << amt;
    return F'(sh);
  endfunction

  // Log-domain add followed by the antilog shift; truncates toward zero.
  // A fraction sum that carries into bit F bumps the characteristic by one
  // and the carried sum itself becomes the mantissa.
  function automatic logic [2*WIDTH_I-1:0] antilog(
    input logic [WIDTH_L-1:0] ka_i,
    input logic [WIDTH_L-1:0] kb_i,
    input logic [F-1:0]       fa_i,
    input logic [F-1:0]       fb_i,
    input logic               zero_i
  );
    logic [WIDTH_L:0]   k_sum;
    logic [WIDTH_L+1:0] k_sh;
    logic [F:0]         s;
    logic [PW-1:0]      mant;
    logic [PW-1:0]      shifted;
    k_sum = {1'b0, ka_i} + {1'b0, kb_i};
    s     = {1'b0, fa_i} + {1'b0, fb_i};
    if (s[F]) begin
      mant = PW'(s);
      k_sh = {1'b0, k_sum} + (WIDTH_L+2)'(1);
    end else begin
      mant = PW'({1'b1, s[F-1:0]});
      k_sh = {1'b0, k_sum};
    end
    shifted = (mant << k_sh) >> F;
    if (zero_i) shifted = '0;
    return (2*WIDTH_I)'(shifted);
  endfunction

  // The single detector sees B only in its own cycle, A otherwise.
  always_comb begin
    lopd_in = (state == LOPD_B) ? opb : opa;
  end

  lopd #(
    .WIDTH_I (WIDTH_I),
    .WIDTH_L (WIDTH_L)
  ) u_lopd (
    .x (lopd_in),
    .k (lopd_k)
  );

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state sequencing and handshake outputs decoded from the state.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = LOPD_A;
      end
      LOPD_A: state_d = LOPD_B;
      LOPD_B: state_d = CALC;
      CALC:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-operand log extraction and the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      zf  <= 1'b0;
      ka  <= '0;
      kb  <= '0;
      fa  <= '0;
      fb  <= '0;
      p   <= '0;
    end else begin
      case (state)
        // accept boundary
        IDLE: begin
          if (in_valid) begin
            opa <= a;
            opb <= b;
            zf  <= (a == '0) | (b == '0);
          end
        end
        // log of A
        LOPD_A: begin
          ka <= lopd_k;
          fa <= frac_of(opa, lopd_k);
        end
        // log of B
        LOPD_B: begin
          kb <= lopd_k;
          fb <= frac_of(opb, lopd_k);
        end
        // antilog; p then holds until the next operation reaches here
        CALC: begin
          p <= antilog(ka, kb, fa, fb, zf);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_log_mul_seq.sv
// Directed and randomized checks of log_mul_seq against an arithmetic
// reference of the Mitchell approximation.
module tb_log_mul_seq;

  localparam int W = 16;
  localparam int F = W - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;
  logic          busy;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  log_mul_seq #(.WIDTH_I(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: x = 2^k (1 + f), log x ~ k + f, product = 2^(ka+kb) (1 + fa + fb)
  // with the carry case 2^(ka+kb+1) (fa + fb); f held as an F-bit integer.
  function automatic logic [31:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned vx, vy, fx, fy, s, prod;
    int kx, ky, kk;
    if (x == 0 || y == 0) return 32'd0;
    vx = longint'(x);
    vy = longint'(y);
    kx = 0;
    while ((vx >> (kx + 1)) != 0) kx++;
    ky = 0;
    while ((vy >> (ky + 1)) != 0) ky++;
    fx = (vx - (64'd1 << kx)) * (64'd1 << (F - kx));
    fy = (vy - (64'd1 << ky)) * (64'd1 << (F - ky));
    s  = fx + fy;
    kk = kx + ky;
    if (s >= (64'd1 << F)) prod = (s * (64'd1 << (kk + 1))) / (64'd1 << F);
    else                   prod = (((64'd1 << F) + s) * (64'd1 << kk)) / (64'd1 << F);
    return prod[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and return just after the accepting edge.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy_wait"}, 64'(in_ready), 64'd1);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  // Edges from the accepting edge (counted as 1) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [31:0] exp, input string tag);
    int lat;
    accept(ta, tb_v, tag);
    wait_out(lat);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_p"}, 64'(p), 64'(exp));
    check({tag, "_inrdy_done"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovld_after"}, 64'(out_valid), 64'd0);
    check({tag, "_p_hold"}, 64'(p), 64'(exp));
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic [31:0]  held;
    logic         rdy;
    int           n;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    rst = 1'b0;
    tick();

    // Reset while B is being detected.
    accept(16'd6, 16'd7, "midrst");
    tick();
    check("midrst_busy_b", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    #1;
    rst = 1'b0;
    tick();
    run_op(16'd4, 16'd5, 32'd20, "after_rst");

    // Carry and no-carry paths, extremes and zero bypass.
    run_op(16'd3, 16'd3, 32'd8, "carry33");
    run_op(16'd6, 16'd7, 32'd40, "carry67");
    run_op(16'd4, 16'd5, 32'd20, "nocarry45");
    run_op(16'hFFFF, 16'd1, 32'd65535, "ffff_x1");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0000, "ffff_sq");
    run_op(16'd0, 16'd7, 32'd0, "zero_a");
    run_op(16'd1234, 16'd0, 32'd0, "zero_b");

    // Backpressure with a new request waiting throughout DONE.
    accept(16'd3, 16'd3, "bp");
    wait_out(lat);
    check("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 16'd9;
      b         = 16'd9;
      check("bp_stall_ovld", 64'(out_valid), 64'd1);
      check("bp_stall_p", 64'(p), 64'd8);
      check("bp_stall_inrdy", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_inrdy", 64'(in_ready), 64'd1);
    check("bp_idle_ovld", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", 64'(busy), 64'd1);
    wait_out(lat);
    check("bp_next_lat", 64'(lat), 64'd4);
    check("bp_next_p", 64'(p), 64'(ref_mul(16'd9, 16'd9)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random pairs with random consumer stalls; each product delivered once, in order.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '0;
        2: ra = '1;
        3: rb = W'($urandom_range(1, 15));
        default: ;
      endcase
      exp_q.push_back(ref_mul(ra, rb));
      accept(ra, rb, "rnd");
      wait_out(lat);
      check("rnd_lat", 64'(lat), 64'd4);
      held = p;
      n    = 0;
      rdy  = 1'b0;
      while (!rdy && n < 16) begin
        rdy       = ($urandom_range(0, 2) == 0) || (n == 15);
        out_ready = rdy;
        if (n > 0) check("rnd_stall_p", 64'(p), 64'(held));
        tick();
        n++;
      end
      out_ready = 1'b0;
      check("rnd_p", 64'(held), 64'(exp_q.pop_front()));
      check("rnd_ovld_after", 64'(out_valid), 64'd0);
    end
    check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
